// File: rtl/inference_scheduler.sv
// Front-end scheduler: streams one image into the single-port image RAM, starts the
// inference engine, watches it with a watchdog and reports the predicted digit.
module inference_scheduler #(
  parameter int IMG_BYTES      = 784,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int CNT_W          = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              img_ram_we,
  output logic [ADDR_W-1:0] img_ram_addr,
  output logic [7:0]        img_ram_wdata,
  input  logic [ADDR_W-1:0] eng_img_addr,
  output logic              inf_start,
  input  logic              inf_done,
  input  logic [3:0]        inf_digit,
  output logic              result_valid,
  output logic [3:0]        result_digit,
  output logic              timeout_err,
  output logic              busy,
  output logic [ADDR_W-1:0] bytes_loaded
);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_REPORT,
    ST_DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);
  localparam logic [CNT_W-1:0]  WD_LIMIT  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_bytes;
  logic [CNT_W-1:0]  r_wd;
  logic [3:0]        r_result_digit;
  logic              r_inf_start;
  logic              r_result_valid;
  logic              r_timeout_err;
  logic              r_busy;

  logic w_in_load;
  logic w_ready;
  logic w_accept;
  logic w_wd_expired;

  // A clear in LOAD blocks the same-cycle byte so the restart always begins at address 0.
  assign w_in_load    = (r_state == ST_LOAD);
  assign w_ready      = w_in_load & ~clear & ~rst;
  assign w_accept     = w_ready & ld_valid;
  assign w_wd_expired = (r_wd >= WD_LIMIT);

  assign ld_ready      = w_ready;
  assign img_ram_we    = w_accept;
  assign img_ram_addr  = w_in_load ? r_bytes : eng_img_addr;
  assign img_ram_wdata = ld_data;
  assign inf_start     = r_inf_start;
  assign result_valid  = r_result_valid;
  assign result_digit  = r_result_digit;
  assign timeout_err   = r_timeout_err;
  assign busy          = r_busy;
  assign bytes_loaded  = r_bytes;

  // NOTE: state and outputs use non-blocking assignments so every register samples
  // pre-edge values, independent of statement order inside this block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_LOAD;
      r_bytes        <= '0;
      r_wd           <= '0;
      r_result_digit <= '0;
      r_inf_start    <= 1'b0;
      r_result_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_inf_start    <= 1'b0;
      r_result_valid <= 1'b0;
      r_timeout_err  <= 1'b0;

      case (r_state)
        ST_LOAD: begin
          if (clear) begin
            r_bytes <= '0;
          end else if (w_accept) begin
            if (r_bytes == LAST_ADDR) begin
              r_bytes     <= '0;
              r_state     <= ST_START;
              r_inf_start <= 1'b1;
              r_busy      <= 1'b1;
            end else begin
              r_bytes <= r_bytes + 1'b1;
            end
          end
        end

        ST_START: begin
          r_wd    <= '0;
          r_state <= clear ? ST_DRAIN : ST_RUN;
        end

        ST_RUN: begin
          r_wd <= r_wd + 1'b1;
          if (clear) begin
            // An abort that coincides with completion has nothing left to drain.
            if (inf_done) begin
              r_state <= ST_LOAD;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else if (inf_done) begin
            r_result_digit <= inf_digit;
            r_result_valid <= 1'b1;
            r_state        <= ST_REPORT;
            r_busy         <= 1'b0;
          end else if (w_wd_expired) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_LOAD;
            r_busy        <= 1'b0;
          end
        end

        ST_DRAIN: begin
          r_wd <= r_wd + 1'b1;
          if (inf_done) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b0;
          end else if (w_wd_expired) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_LOAD;
            r_busy        <= 1'b0;
          end
        end

        ST_REPORT: begin
          r_state <= ST_LOAD;
        end

        default: begin
          r_state <= ST_LOAD;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inference_scheduler.sv
// Directed bench for inference_scheduler: load/start/run/report, clear, async reset,
// plus a second instance with a short watchdog for the timeout path.
module tb_inference_scheduler;

  localparam int AW = 10;
  localparam int NB = 784;

  logic          clk, rst;
  logic          clear, ld_valid;
  logic [7:0]    ld_data;
  logic          ld_ready, img_ram_we;
  logic [AW-1:0] img_ram_addr;
  logic [7:0]    img_ram_wdata;
  logic [AW-1:0] eng_img_addr;
  logic          inf_start, inf_done;
  logic [3:0]    inf_digit;
  logic          result_valid;
  logic [3:0]    result_digit;
  logic          timeout_err, busy;
  logic [AW-1:0] bytes_loaded;

  logic          t_clear, t_ld_valid;
  logic [7:0]    t_ld_data;
  logic          t_ld_ready, t_we;
  logic [AW-1:0] t_addr;
  logic [7:0]    t_wdata;
  logic [AW-1:0] t_eng_addr;
  logic          t_inf_start, t_inf_done;
  logic [3:0]    t_inf_digit;
  logic          t_result_valid;
  logic [3:0]    t_result_digit;
  logic          t_timeout_err, t_busy;
  logic [AW-1:0] t_bytes_loaded;

  int total = 0;
  int bad   = 0;

  inference_scheduler dut (
    .clk(clk), .rst(rst), .clear(clear), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .img_ram_we(img_ram_we), .img_ram_addr(img_ram_addr),
    .img_ram_wdata(img_ram_wdata), .eng_img_addr(eng_img_addr), .inf_start(inf_start),
    .inf_done(inf_done), .inf_digit(inf_digit), .result_valid(result_valid),
    .result_digit(result_digit), .timeout_err(timeout_err), .busy(busy),
    .bytes_loaded(bytes_loaded)
  );

  inference_scheduler #(.TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .rst(rst), .clear(t_clear), .ld_valid(t_ld_valid), .ld_data(t_ld_data),
    .ld_ready(t_ld_ready), .img_ram_we(t_we), .img_ram_addr(t_addr),
    .img_ram_wdata(t_wdata), .eng_img_addr(t_eng_addr), .inf_start(t_inf_start),
    .inf_done(t_inf_done), .inf_digit(t_inf_digit), .result_valid(t_result_valid),
    .result_digit(t_result_digit), .timeout_err(t_timeout_err), .busy(t_busy),
    .bytes_loaded(t_bytes_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix(input int i);
    return 8'((i * 7 + 3) ^ (i >> 3));
  endfunction

  task automatic load_bytes(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      ld_valid = 1'b1;
      ld_data  = pix(i);
      #1;
      total++;
      if ({img_ram_we, ld_ready, img_ram_addr, img_ram_wdata, bytes_loaded} !==
          {1'b1, 1'b1, AW'(i), pix(i), AW'(i)}) begin
        bad++;
        $display("FAIL load_byte[%0d]: we=%b rdy=%b addr=%0d data=%h cnt=%0d, want we=1 rdy=1 addr=%0d data=%h cnt=%0d",
                 i, img_ram_we, ld_ready, img_ram_addr, img_ram_wdata, bytes_loaded, i, pix(i), i);
      end
      tick();
    end
  endtask

  // Called in the cycle right after the last byte was accepted; returns at the first RUN cycle.
  task automatic check_start(input string tag);
    #1;
    total++;
    if ({inf_start, busy, ld_ready, img_ram_we, bytes_loaded} !== {1'b1, 1'b1, 1'b0, 1'b0, AW'(0)}) begin
      bad++;
      $display("FAIL %s_start: start=%b busy=%b rdy=%b we=%b cnt=%0d, want 1 1 0 0 0",
               tag, inf_start, busy, ld_ready, img_ram_we, bytes_loaded);
    end
    tick();
    total++;
    if ({inf_start, busy} !== 2'b01) begin
      bad++;
      $display("FAIL %s_start_pulse: start=%b busy=%b, want start=0 busy=1", tag, inf_start, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; ld_valid = 1'b1; ld_data = 8'h00; eng_img_addr = '0;
    inf_done = 1'b0; inf_digit = '0;
    t_clear = 1'b0; t_ld_valid = 1'b0; t_ld_data = '0; t_eng_addr = '0;
    t_inf_done = 1'b0; t_inf_digit = '0;
    #2;
    total++;
    if ({ld_ready, img_ram_we, inf_start, result_valid, timeout_err, busy, bytes_loaded, result_digit} !==
        {6'b0, AW'(0), 4'd0}) begin
      bad++;
      $display("FAIL reset_values: rdy=%b we=%b start=%b rv=%b to=%b busy=%b cnt=%0d digit=%0d, want all 0",
               ld_ready, img_ram_we, inf_start, result_valid, timeout_err, busy, bytes_loaded, result_digit);
    end
    tick(); tick();
    ld_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: ld_ready=%b, want 1", ld_ready);
    end
    tick();
  endtask

  task automatic test_load_run_report();
    logic [AW-1:0] tbl [3];
    logic          ok;
    tbl[0] = AW'(5); tbl[1] = AW'(300); tbl[2] = AW'(783);
    load_bytes(0, NB);
    check_start("main");
    ld_valid = 1'b1;
    ok = 1'b1;
    for (int j = 1; j < 500; j++) begin
      eng_img_addr = tbl[j % 3];
      #1;
      total++;
      if ({ld_ready, img_ram_we, inf_start, result_valid, timeout_err, busy, img_ram_addr} !==
          {6'b000001, tbl[j % 3]}) begin
        bad++;
        $display("FAIL run_cycle[%0d]: rdy=%b we=%b start=%b rv=%b to=%b busy=%b addr=%0d, want 0 0 0 0 0 1 addr=%0d",
                 j, ld_ready, img_ram_we, inf_start, result_valid, timeout_err, busy, img_ram_addr, tbl[j % 3]);
      end
      tick();
    end
    inf_done = 1'b1; inf_digit = 4'd7;
    tick();
    inf_done = 1'b0; inf_digit = 4'd0;
    #1;
    total++;
    if ({result_valid, result_digit, busy, ld_ready} !== {1'b1, 4'd7, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL report: rv=%b digit=%0d busy=%b rdy=%b, want rv=1 digit=7 busy=0 rdy=0",
               result_valid, result_digit, busy, ld_ready);
    end
    tick();
    ld_data = 8'hA5;
    #1;
    total++;
    if ({ld_ready, img_ram_we, img_ram_addr, img_ram_wdata, result_valid, result_digit} !==
        {1'b1, 1'b1, AW'(0), 8'hA5, 1'b0, 4'd7}) begin
      bad++;
      $display("FAIL rearm: rdy=%b we=%b addr=%0d data=%h rv=%b digit=%0d, want 1 1 0 a5 0 7",
               ld_ready, img_ram_we, img_ram_addr, img_ram_wdata, result_valid, result_digit);
    end
    tick();
  endtask

  task automatic test_clear_load();
    load_bytes(1, 99);
    ld_valid = 1'b1; ld_data = 8'h3C; clear = 1'b1;
    #1;
    total++;
    if ({bytes_loaded, ld_ready, img_ram_we} !== {AW'(100), 2'b00}) begin
      bad++;
      $display("FAIL clear_load_block: cnt=%0d rdy=%b we=%b, want cnt=100 rdy=0 we=0",
               bytes_loaded, ld_ready, img_ram_we);
    end
    tick();
    clear = 1'b0;
    #1;
    total++;
    if ({bytes_loaded, img_ram_addr, img_ram_we} !== {AW'(0), AW'(0), 1'b1}) begin
      bad++;
      $display("FAIL clear_load_restart: cnt=%0d addr=%0d we=%b, want 0 0 1",
               bytes_loaded, img_ram_addr, img_ram_we);
    end
    load_bytes(0, NB);
    check_start("clr");
  endtask

  task automatic test_clear_run();
    tick(); tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0; eng_img_addr = AW'(300);
    #1;
    total++;
    if ({busy, ld_ready, img_ram_we, result_valid, img_ram_addr} !== {4'b1000, AW'(300)}) begin
      bad++;
      $display("FAIL drain: busy=%b rdy=%b we=%b rv=%b addr=%0d, want 1 0 0 0 300",
               busy, ld_ready, img_ram_we, result_valid, img_ram_addr);
    end
    tick(); tick(); tick(); tick(); tick();
    inf_done = 1'b1; inf_digit = 4'd3;
    tick();
    inf_done = 1'b0; inf_digit = 4'd0; ld_valid = 1'b0;
    #1;
    total++;
    if ({ld_ready, result_valid, busy, timeout_err, result_digit} !== {4'b1000, 4'd7}) begin
      bad++;
      $display("FAIL drain_exit: rdy=%b rv=%b busy=%b to=%b digit=%0d, want 1 0 0 0 7",
               ld_ready, result_valid, busy, timeout_err, result_digit);
    end
    tick();
    total++;
    if (result_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_no_result: rv=%b, want 0", result_valid);
    end
  endtask

  task automatic test_async_reset();
    load_bytes(0, 50);
    rst = 1'b1;
    #1;
    total++;
    if ({bytes_loaded, ld_ready, img_ram_we, busy} !== {AW'(0), 3'b000}) begin
      bad++;
      $display("FAIL rst_mid_load: cnt=%0d rdy=%b we=%b busy=%b, want 0 0 0 0",
               bytes_loaded, ld_ready, img_ram_we, busy);
    end
    tick(); tick();
    rst = 1'b0;
    load_bytes(0, NB);
    check_start("rst1");
    eng_img_addr = AW'(300);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    total++;
    if ({inf_start, result_valid, timeout_err, busy, ld_ready, img_ram_we, bytes_loaded, result_digit, img_ram_addr} !==
        {6'b0, AW'(0), 4'd0, AW'(0)}) begin
      bad++;
      $display("FAIL rst_mid_run: start=%b rv=%b to=%b busy=%b rdy=%b we=%b cnt=%0d digit=%0d addr=%0d, want all 0",
               inf_start, result_valid, timeout_err, busy, ld_ready, img_ram_we, bytes_loaded,
               result_digit, img_ram_addr);
    end
    tick(); tick();
    rst = 1'b0;
    load_bytes(0, NB);
    check_start("rst2");
    ld_valid = 1'b0;
    for (int j = 0; j < 9; j++) tick();
    inf_done = 1'b1; inf_digit = 4'd9;
    tick();
    inf_done = 1'b0; inf_digit = 4'd0;
    #1;
    total++;
    if ({result_valid, result_digit} !== {1'b1, 4'd9}) begin
      bad++;
      $display("FAIL rst_fresh_image: rv=%b digit=%0d, want rv=1 digit=9", result_valid, result_digit);
    end
    tick();
  endtask

  task automatic t_load();
    for (int i = 0; i < NB; i++) begin
      t_ld_valid = 1'b1;
      t_ld_data  = 8'(i);
      tick();
    end
    t_ld_valid = 1'b0;
    #1;
    total++;
    if ({t_inf_start, t_busy} !== 2'b11) begin
      bad++;
      $display("FAIL to_start: start=%b busy=%b, want 1 1", t_inf_start, t_busy);
    end
  endtask

  task automatic test_timeout();
    t_load();
    tick(); tick();
    t_inf_done = 1'b1; t_inf_digit = 4'd5;
    tick();
    t_inf_done = 1'b0; t_inf_digit = 4'd0;
    #1;
    total++;
    if ({t_result_valid, t_result_digit} !== {1'b1, 4'd5}) begin
      bad++;
      $display("FAIL to_first_result: rv=%b digit=%0d, want 1 5", t_result_valid, t_result_digit);
    end
    tick();
    t_load();
    for (int c = 1; c <= 17; c++) begin
      tick();
      total++;
      if (c < 17) begin
        if ({t_timeout_err, t_result_valid, t_busy} !== 3'b001) begin
          bad++;
          $display("FAIL to_wait[%0d]: to=%b rv=%b busy=%b, want 0 0 1", c, t_timeout_err, t_result_valid, t_busy);
        end
      end else begin
        if ({t_timeout_err, t_result_valid, t_busy, t_ld_ready, t_result_digit} !== {4'b1001, 4'd5}) begin
          bad++;
          $display("FAIL to_fire: to=%b rv=%b busy=%b rdy=%b digit=%0d, want 1 0 0 1 5",
                   t_timeout_err, t_result_valid, t_busy, t_ld_ready, t_result_digit);
        end
      end
    end
    tick();
    total++;
    if ({t_timeout_err, t_result_valid} !== 2'b00) begin
      bad++;
      $display("FAIL to_pulse_width: to=%b rv=%b, want 0 0", t_timeout_err, t_result_valid);
    end
  endtask

  initial begin
    test_reset();
    test_load_run_report();
    test_clear_load();
    test_clear_run();
    test_async_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
